// File: rtl/perf_sample_writer.sv
// perf_sample_writer
// ------------------
// Sampling engine on the trigger side of the perf counter block. An accepted
// trigger captures a snapshot of the commit PC, the cycle and instret counters,
// and the generic counters. The snapshot is written as one RecordWords x 64-bit
// record into a memory-mapped ring buffer, through a req/gnt store port that is
// arbitrated into the D-cache.
//
// Record layout (one 64-bit word per store):
//   w0 = {seq[31:0], 28'b0, src[3:0]}, w1 = pc, w2 = cycle, w3 = instret,
//   w4+k = generic counter k
// Word address = base + (wr_ptr*RecordWords + w)*8, computed modulo 2^64.
//
// Optional feature: define PERF_SAMPLE_IRQ_EN to build the ring-wrap interrupt.
// When it is not defined, irq_o is tied low and no wrap detection is built.
//
// Ports:
//   clk_i, rst_ni        clock; asynchronous active-low reset
//   enable_i             sampling enabled
//   debug_mode_i         core in debug mode; triggers are ignored
//   trigger_i            single-cycle sample request
//   trigger_src_i        0=cycle, 1=instret, 2.. = generic counter index + 1
//   pc_i, cycle_count_i, instr_count_i, counters_i   snapshot sources
//   base_addr_i          ring base address, 8-byte aligned
//   ring_clr_i           clear wr_ptr, seq and dropped (honoured in IDLE only)
//   mem_req_o/mem_gnt_i  store handshake; mem_addr_o/mem_wdata_o/mem_be_o payload
//   busy_o               record in flight
//   sample_done_o        one-cycle pulse after the final word is accepted
//   wr_ptr_o             next ring slot
//   dropped_o            triggers lost while busy (saturating)
//   irq_o                ring-wrap interrupt
module perf_sample_writer #(
  parameter int NumCounters = 6,
  parameter int RingEntries = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic                          debug_mode_i,
  input  logic                          trigger_i,
  input  logic [3:0]                    trigger_src_i,
  input  logic [63:0]                   pc_i,
  input  logic [63:0]                   cycle_count_i,
  input  logic [63:0]                   instr_count_i,
  input  logic [NumCounters*64-1:0]     counters_i,
  input  logic [63:0]                   base_addr_i,
  input  logic                          ring_clr_i,
  output logic                          mem_req_o,
  input  logic                          mem_gnt_i,
  output logic [63:0]                   mem_addr_o,
  output logic [63:0]                   mem_wdata_o,
  output logic [7:0]                    mem_be_o,
  output logic                          busy_o,
  output logic                          sample_done_o,
  output logic [$clog2(RingEntries)-1:0] wr_ptr_o,
  output logic [31:0]                   dropped_o,
  output logic                          irq_o
);

  localparam int RecordWords = NumCounters + 4;
  localparam int PtrW        = $clog2(RingEntries);
  localparam int WordW       = $clog2(RecordWords);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Control state
  logic [WordW-1:0] word_q;
  logic [PtrW-1:0]  wr_ptr_q;
  logic [31:0]      seq_q;
  logic [31:0]      dropped_q;
  logic             done_q;

  // Snapshot captured on the accepting edge
  logic [63:0]                       pc_p0;
  logic [63:0]                       cycle_p0;
  logic [63:0]                       instr_p0;
  logic [NumCounters-1:0][63:0]      cnt_p0;
  logic [3:0]                        src_p0;
  logic [63:0]                       base_p0;
  logic [31:0]                       seq_p0;

  logic        accept;
  logic        last_gnt;
  logic        clr_idle;
  logic        drop;
  logic [63:0] word_mux;
  logic [63:0] slot_word;
  logic [63:0] word_addr;

  assign accept   = (state_q == IDLE) && trigger_i && enable_i && !debug_mode_i;
  assign last_gnt = (state_q == WRITE) && mem_gnt_i &&
                    (word_q == WordW'(RecordWords - 1));
  assign clr_idle = (state_q == IDLE) && ring_clr_i;
  // Any trigger seen while a record is in flight is lost, including the
  // final-grant cycle.
  assign drop     = (state_q == WRITE) && trigger_i;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = WRITE;
      WRITE:   if (last_gnt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Payload is forced to zero outside WRITE so the bus is quiet at reset
  // without resetting the snapshot registers.
  always_comb begin
    mem_req_o   = (state_q == WRITE);
    busy_o      = (state_q == WRITE);
    mem_be_o    = mem_req_o ? 8'hFF : 8'h00;
    mem_addr_o  = mem_req_o ? word_addr : 64'h0;
    mem_wdata_o = mem_req_o ? word_mux : 64'h0;
  end

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q    <= '0;
      wr_ptr_q  <= '0;
      seq_q     <= '0;
      dropped_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= last_gnt;

      if (accept || last_gnt)                     word_q <= '0;
      else if ((state_q == WRITE) && mem_gnt_i)   word_q <= word_q + WordW'(1);

      if (clr_idle)      wr_ptr_q <= '0;
      else if (last_gnt) wr_ptr_q <= wr_ptr_q + PtrW'(1);

      if (clr_idle)      seq_q <= '0;
      else if (last_gnt) seq_q <= seq_q + 32'd1;

      if (clr_idle)                          dropped_q <= '0;
      else if (drop && (dropped_q != '1))    dropped_q <= dropped_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------- snapshot (p0)
  // A clear coinciding with an accepted trigger takes effect first, so the
  // record carries seq 0 (and lands in slot 0, since wr_ptr is cleared too).
  always_ff @(posedge clk_i) begin
    if (accept) begin
      pc_p0    <= pc_i;
      cycle_p0 <= cycle_count_i;
      instr_p0 <= instr_count_i;
      cnt_p0   <= counters_i;
      src_p0   <= trigger_src_i;
      base_p0  <= base_addr_i;
      seq_p0   <= ring_clr_i ? 32'h0 : seq_q;
    end
  end

  // ---------------------------------------------------------------- word select
  always_comb begin
    word_mux = 64'h0;
    if (word_q == WordW'(0))      word_mux = {seq_p0, 28'h0, src_p0};
    else if (word_q == WordW'(1)) word_mux = pc_p0;
    else if (word_q == WordW'(2)) word_mux = cycle_p0;
    else if (word_q == WordW'(3)) word_mux = instr_p0;
    else begin
      for (int k = 0; k < NumCounters; k++) begin
        if (word_q == WordW'(k + 4)) word_mux = cnt_p0[k];
      end
    end
  end

  assign slot_word = 64'(wr_ptr_q) * 64'(RecordWords) + 64'(word_q);
  assign word_addr = base_p0 + {slot_word[60:0], 3'b000};

  assign sample_done_o = done_q;
  assign wr_ptr_o      = wr_ptr_q;
  assign dropped_o     = dropped_q;

`ifdef PERF_SAMPLE_IRQ_EN
  // ---------------------------------------------------------------- wrap interrupt
  logic irq_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                                 irq_q <= 1'b0;
    else if (clr_idle)                                           irq_q <= 1'b0;
    else if (last_gnt && (wr_ptr_q == PtrW'(RingEntries - 1)))   irq_q <= 1'b1;
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_perf_sample_writer.sv
// Directed bench for perf_sample_writer (NumCounters=6, RingEntries=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_perf_sample_writer;

  localparam int NC = 6;
  localparam int RE = 4;
  localparam int RW = NC + 4;

`ifdef PERF_SAMPLE_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              enable_i;
  logic              debug_mode_i;
  logic              trigger_i;
  logic [3:0]        trigger_src_i;
  logic [63:0]       pc_i;
  logic [63:0]       cycle_count_i;
  logic [63:0]       instr_count_i;
  logic [NC*64-1:0]  counters_i;
  logic [63:0]       base_addr_i;
  logic              ring_clr_i;
  logic              mem_req_o;
  logic              mem_gnt_i;
  logic [63:0]       mem_addr_o;
  logic [63:0]       mem_wdata_o;
  logic [7:0]        mem_be_o;
  logic              busy_o;
  logic              sample_done_o;
  logic [1:0]        wr_ptr_o;
  logic [31:0]       dropped_o;
  logic              irq_o;

  perf_sample_writer #(
    .NumCounters(NC),
    .RingEntries(RE)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .enable_i      (enable_i),
    .debug_mode_i  (debug_mode_i),
    .trigger_i     (trigger_i),
    .trigger_src_i (trigger_src_i),
    .pc_i          (pc_i),
    .cycle_count_i (cycle_count_i),
    .instr_count_i (instr_count_i),
    .counters_i    (counters_i),
    .base_addr_i   (base_addr_i),
    .ring_clr_i    (ring_clr_i),
    .mem_req_o     (mem_req_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_be_o      (mem_be_o),
    .busy_o        (busy_o),
    .sample_done_o (sample_done_o),
    .wr_ptr_o      (wr_ptr_o),
    .dropped_o     (dropped_o),
    .irq_o         (irq_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int nwrites = 0;

  always @(posedge clk) if (mem_req_o && mem_gnt_i) nwrites <= nwrites + 1;

  logic [63:0] pc_v, cyc_v, ins_v, base_v;
  logic [63:0] cnt_v [NC];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_inputs();
    pc_i          = pc_v;
    cycle_count_i = cyc_v;
    instr_count_i = ins_v;
    for (int k = 0; k < NC; k++) counters_i[k*64 +: 64] = cnt_v[k];
    base_addr_i   = base_v;
  endtask

  // Disturb every snapshot source once the record has been captured.
  task automatic scramble();
    pc_i          = ~pc_v;
    cycle_count_i = cyc_v + 64'd7;
    instr_count_i = ins_v + 64'd9;
    counters_i    = ~counters_i;
    base_addr_i   = base_v + 64'h1000;
  endtask

  function automatic logic [63:0] exp_word(input int w, input logic [31:0] seq,
                                           input logic [3:0] src);
    case (w)
      0:       return {seq, 28'h0, src};
      1:       return pc_v;
      2:       return cyc_v;
      3:       return ins_v;
      default: return cnt_v[w-4];
    endcase
  endfunction

  // One full record. stall_n cycles of withheld grant on word stall_w;
  // drops: extra triggers at w=2 (with a ring clear) and in the final-gnt cycle;
  // gate: enable low / debug high for the whole record after capture.
  task automatic run_record(input logic [31:0] seq, input int slot, input logic [3:0] src,
                            input int stall_w, input int stall_n, input bit drops,
                            input bit clr_with_trig, input bit gate);
    int start;
    int s;
    logic [63:0] ea;
    apply_inputs();
    trigger_src_i = src;
    trigger_i     = 1'b1;
    ring_clr_i    = clr_with_trig;
    mem_gnt_i     = 1'b0;
    start         = nwrites;
    @(negedge clk);
    trigger_i  = 1'b0;
    ring_clr_i = 1'b0;
    scramble();
    if (gate) begin
      enable_i     = 1'b0;
      debug_mode_i = 1'b1;
    end
    for (int w = 0; w < RW; w++) begin
      s = (w == stall_w) ? stall_n : 0;
      for (int i = 0; i <= s; i++) begin
        ea = base_v + 64'((slot * RW + w) * 8);
        chk("req", 64'(mem_req_o), 64'd1);
        chk("addr", mem_addr_o, ea);
        chk("wdata", mem_wdata_o, exp_word(w, seq, src));
        if (i == 0) begin
          chk("be", 64'(mem_be_o), 64'hFF);
          chk("busy", 64'(busy_o), 64'd1);
        end
        mem_gnt_i  = (i == s);
        trigger_i  = drops && ((w == 2 && i == 0) || (w == RW - 1));
        ring_clr_i = drops && (w == 2) && (i == 0);
        @(negedge clk);
        trigger_i  = 1'b0;
        ring_clr_i = 1'b0;
      end
    end
    mem_gnt_i    = 1'b0;
    enable_i     = 1'b1;
    debug_mode_i = 1'b0;
    chk("req_end", 64'(mem_req_o), 64'd0);
    chk("busy_end", 64'(busy_o), 64'd0);
    chk("done_pulse", 64'(sample_done_o), 64'd1);
    chk("wr_ptr", 64'(wr_ptr_o), 64'((slot + 1) % RE));
    chk("nwrites", 64'(nwrites - start), 64'(RW));
    @(negedge clk);
    chk("done_clear", 64'(sample_done_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni        = 1'b0;
    enable_i      = 1'b1;
    debug_mode_i  = 1'b0;
    trigger_i     = 1'b0;
    trigger_src_i = 4'd0;
    ring_clr_i    = 1'b0;
    mem_gnt_i     = 1'b0;
    pc_v          = 64'h0000_0000_8000_1234;
    cyc_v         = 64'h1111_2222_3333_4444;
    ins_v         = 64'h5555_6666_7777_8888;
    base_v        = 64'h0000_0000_8000_0000;
    for (int k = 0; k < NC; k++) cnt_v[k] = 64'hC0DE_0000_0000_0000 | 64'(k);
    apply_inputs();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", 64'(mem_req_o), 64'd0);
    chk("rst_be", 64'(mem_be_o), 64'd0);
    chk("rst_addr", mem_addr_o, 64'd0);
    chk("rst_wdata", mem_wdata_o, 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(sample_done_o), 64'd0);
    chk("rst_wr_ptr", 64'(wr_ptr_o), 64'd0);
    chk("rst_dropped", 64'(dropped_o), 64'd0);
    chk("rst_irq", 64'(irq_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    // Basic record: src 2, first word is 0x2, words at 0x8000_0000..0x48
    chk("basic_w0_model", exp_word(0, 32'd0, 4'd2), 64'h2);
    run_record(32'd0, 0, 4'd2, -1, 0, 1'b0, 1'b0, 1'b0);

    // Ring clear in IDLE
    ring_clr_i = 1'b1;
    @(negedge clk);
    ring_clr_i = 1'b0;
    chk("clr_wr_ptr", 64'(wr_ptr_o), 64'd0);
    chk("clr_dropped", 64'(dropped_o), 64'd0);

    // Backpressure: grant withheld 3 cycles on w=4 (address 0x8000_0020);
    // enable/debug toggled during the record must not abort it
    cyc_v = 64'h0000_0000_0000_1000;
    run_record(32'd0, 0, 4'd3, 4, 3, 1'b0, 1'b0, 1'b1);

    // Drop while busy (plus a ring clear inside WRITE, which is ignored)
    cyc_v = 64'h0000_0000_0000_2000;
    run_record(32'd1, 1, 4'd7, -1, 0, 1'b1, 1'b0, 1'b0);
    chk("dropped_two", 64'(dropped_o), 64'd2);

    // Next record after the drops: seq 2, slot 2 (base + 0xA0)
    ins_v = 64'h0000_0000_0000_0AAA;
    run_record(32'd2, 2, 4'd0, -1, 0, 1'b0, 1'b0, 1'b0);

    // Gating: debug mode, then enable low -> nothing happens
    debug_mode_i = 1'b1;
    trigger_i    = 1'b1;
    @(negedge clk);
    trigger_i    = 1'b0;
    debug_mode_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("gate_dbg_req", 64'(mem_req_o), 64'd0);
    chk("gate_dbg_busy", 64'(busy_o), 64'd0);
    enable_i  = 1'b0;
    trigger_i = 1'b1;
    @(negedge clk);
    trigger_i = 1'b0;
    enable_i  = 1'b1;
    repeat (2) @(negedge clk);
    chk("gate_en_req", 64'(mem_req_o), 64'd0);
    chk("gate_dropped", 64'(dropped_o), 64'd2);
    chk("gate_wr_ptr", 64'(wr_ptr_o), 64'd3);

    // Wrap: slot 3 then slot 0 again
    run_record(32'd3, 3, 4'd1, -1, 0, 1'b0, 1'b0, 1'b0);
    chk("irq_after_wrap", 64'(irq_o), 64'(IRQ_EXP));
    pc_v = 64'hFFFF_FFFF_FFFF_FFF0;
    run_record(32'd4, 0, 4'd5, -1, 0, 1'b0, 1'b0, 1'b0);
    chk("irq_held", 64'(irq_o), 64'(IRQ_EXP));

    // Clear coinciding with a trigger: record uses seq 0, slot 0
    run_record(32'd0, 0, 4'd6, -1, 0, 1'b0, 1'b1, 1'b0);
    chk("irq_cleared", 64'(irq_o), 64'd0);
    chk("clr_trig_dropped", 64'(dropped_o), 64'd0);

    // Reset in the middle of a record (at w=5)
    apply_inputs();
    trigger_src_i = 4'd4;
    trigger_i     = 1'b1;
    mem_gnt_i     = 1'b1;
    @(negedge clk);
    trigger_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_addr_w5", mem_addr_o, base_v + 64'((1 * RW + 5) * 8));
    rst_ni = 1'b0;
    #1;
    chk("rst_async_req", 64'(mem_req_o), 64'd0);
    chk("rst_async_busy", 64'(busy_o), 64'd0);
    mem_gnt_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("post_rst_wr_ptr", 64'(wr_ptr_o), 64'd0);
    chk("post_rst_dropped", 64'(dropped_o), 64'd0);
    chk("post_rst_done", 64'(sample_done_o), 64'd0);
    run_record(32'd0, 0, 4'd4, -1, 0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/perf_sample_writer.md
Name: perf_sample_writer

Overview:
- Sampling engine on the trigger side of the perf counter block.
- On each threshold trigger (cycle, instret or a generic counter crossing its threshold), it captures a snapshot of the counters.
- It writes the snapshot as one fixed-size record into a memory-mapped ring buffer, through a req/gnt store port arbitrated into the D-cache.
- It tracks the ring write pointer, a sequence number, and triggers dropped while busy.

Parameters:
- NumCounters, 6: generic counters in each record.
- RingEntries, 64: records in the ring; power of two, >=2.
- RecordWords, NumCounters+4: 64-bit words per record (derived; do not override).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- enable_i  in  1  sampling enabled
- debug_mode_i  in  1  core in debug mode; triggers ignored
- trigger_i  in  1  single-cycle sample request
- trigger_src_i  in  4  0=cycle, 1=instret, 2..(NumCounters+1)=generic counter index+1
- pc_i  in  64  PC of the commit port 0 instruction
- cycle_count_i  in  64  cycle counter
- instr_count_i  in  64  instret counter
- counters_i  in  NumCounters*64  generic counters; counter k occupies bits [64k+63:64k]
- base_addr_i  in  64  ring base address, 8-byte aligned
- ring_clr_i  in  1  clear pointer, sequence and drop count
- mem_req_o  out  1  store request
- mem_gnt_i  in  1  store accepted this cycle
- mem_addr_o  out  64  store address
- mem_wdata_o  out  64  store data
- mem_be_o  out  8  byte enables, always 8'hFF while req
- busy_o  out  1  record in flight
- sample_done_o  out  1  one-cycle pulse: record complete
- wr_ptr_o  out  $clog2(RingEntries)  next ring slot
- dropped_o  out  32  triggers lost, saturating
- irq_o  out  1  ring-wrap interrupt (see Optional Feature)

Behaviour:
- Reset: state IDLE. All outputs 0 except mem_be_o, which is 0 until the first req. wr_ptr, seq and dropped are all 0.
- FSM states: IDLE, WRITE.
- IDLE -> WRITE: taken when trigger_i && enable_i && !debug_mode_i.
  - On that edge, latch the snapshot: pc, cycle, instret, counters, src, base_addr_i and the current seq.
  - mem_req_o rises the next cycle.
- Record layout, word w:
  - w0 = {seq[31:0], 28'b0, src[3:0]}
  - w1 = pc
  - w2 = cycle
  - w3 = instret
  - w4+k = counter k
- Address: mem_addr_o = base_latched + (wr_ptr*RecordWords + w)*8, computed mod 2^64.
- WRITE handshake:
  - mem_req_o is held high, with addr/data stable, until mem_gnt_i.
  - On a gnt, w increments; at most one word per cycle.
- Final word: gnt on w=RecordWords-1 returns the FSM to IDLE, and on that edge:
  - wr_ptr increments, wrapping RingEntries-1 -> 0;
  - seq increments, wrapping at 2^32;
  - sample_done_o pulses in the following cycle.
- busy_o equals (state==WRITE).
- Trigger while in WRITE (including the final-gnt cycle): increment dropped_o, saturating at 32'hFFFF_FFFF. No capture.
- Trigger in IDLE that is blocked by !enable_i or debug_mode_i: ignored, not counted as dropped.
- enable_i or debug_mode_i asserting during WRITE: the current record completes; no abort.
- base_addr_i changing during WRITE: no effect until the next capture.
- ring_clr_i in IDLE: wr_ptr, seq and dropped are cleared on the next edge, and irq_o is cleared.
  - If ring_clr_i and an accepted trigger coincide, the clear applies first; the record uses seq 0 and slot 0.
- ring_clr_i in WRITE: ignored.
- Reset mid-record: mem_req_o drops asynchronously; the partial record is abandoned and all state returns to reset values.

Optional Feature:
- Macro: PERF_SAMPLE_IRQ_EN.
- Defined: irq_o sets on the final-gnt edge at which wr_ptr wraps RingEntries-1 -> 0. It stays high until ring_clr_i is accepted or reset.
- Undefined: irq_o is tied to 0, and the wrap detection logic is not built.

Test Plan:
- Basic record: base=0x8000_0000, trigger src=2, gnt tied 1 -> 10 writes at 0x8000_0000..0x8000_0048, one per cycle. w0=0x0000_0000_0000_0002. sample_done_o pulses 1 cycle after the last gnt. wr_ptr_o=1.
- Backpressure: gnt withheld 3 cycles on w=4 -> mem_addr_o=0x8000_0020 and data stable for 4 cycles; no word skipped or repeated; 10 gnts total.
- Drop while busy: second trigger during WRITE, then another in the final-gnt cycle -> dropped_o=2 and exactly 10 writes. The next trigger after done uses seq 1 and addr base+0x50.
- Wrap: RingEntries=4, 5 triggers -> the 5th record is at base+0x0 with seq 4. wr_ptr_o sequence is 1,2,3,0,1. With PERF_SAMPLE_IRQ_EN, irq_o rises after the 4th record; ring_clr_i clears it.
- Gating: trigger with debug_mode_i=1, then trigger with enable_i=0 -> no mem_req_o, dropped_o=0.
- Reset mid-record: rst_ni low at w=5 -> mem_req_o=0 immediately. After release, wr_ptr_o=0 and the next record has seq 0.
